// File: rtl/uart_arb_pkg.sv
// +----------------------------------------------------------------------+
// | uart_arb_pkg : shared types and helpers for uart_tx_arbiter           |
// | Optional feature macro: UART_ARB_TAG_EN (adds the TAG state)          |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

package uart_arb_pkg;

`ifdef UART_ARB_TAG_EN
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEND    = 3'd1,
    ST_START   = 3'd2,
    ST_WAIT_HI = 3'd3,
    ST_WAIT_LO = 3'd4,
    ST_TAG     = 3'd5
  } arb_state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEND    = 3'd1,
    ST_START   = 3'd2,
    ST_WAIT_HI = 3'd3,
    ST_WAIT_LO = 3'd4
  } arb_state_t;
`endif

  // Marker placed in the MSB of a tag byte.
  localparam logic TAG_FLAG = 1'b1;

  function automatic int id_bits(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick.sv
// +----------------------------------------------------------------------+
// | rr_pick : combinational round-robin winner search from a pointer     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQUESTERS = 4
) (
  input  logic [NUM_REQUESTERS-1:0]              i_req_valid,
  input  logic [id_bits(NUM_REQUESTERS)-1:0]     i_rr_ptr,
  output logic [NUM_REQUESTERS-1:0]              o_onehot,
  output logic [id_bits(NUM_REQUESTERS)-1:0]     o_idx,
  output logic                                   o_any
);

  localparam int ID_W = id_bits(NUM_REQUESTERS);

  logic [ID_W-1:0] w_pos;

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    w_pos    = '0;
    // First valid index at or above the pointer, wrapping past the top.
    for (int k = 0; k < NUM_REQUESTERS; k++) begin
      w_pos = ID_W'((int'(i_rr_ptr) + k) % NUM_REQUESTERS);
      if (!o_any && i_req_valid[w_pos]) begin
        o_any           = 1'b1;
        o_idx           = w_pos;
        o_onehot[w_pos] = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// +----------------------------------------------------------------------+
// | uart_tx_arbiter : round-robin burst arbiter sharing one uart_tx       |
// | Optional feature macro: UART_ARB_TAG_EN (source tag byte per grant)   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQUESTERS = 4,
  parameter int WIDTH          = 8,
  parameter int MAX_BURST      = 16
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic [NUM_REQUESTERS-1:0]              req_valid,
  input  logic [NUM_REQUESTERS-1:0][WIDTH-1:0]   req_data,
  input  logic [NUM_REQUESTERS-1:0]              req_last,
  output logic [NUM_REQUESTERS-1:0]              req_ready,
  output logic [WIDTH-1:0]                       tx_data,
  output logic                                   tx_start,
  input  logic                                   tx_busy,
  output logic [id_bits(NUM_REQUESTERS)-1:0]     grant_id,
  output logic                                   grant_active
);

  localparam int ID_W = id_bits(NUM_REQUESTERS);
  localparam int BC_W = $clog2(MAX_BURST + 1);
  localparam logic [ID_W-1:0] c_last_id   = ID_W'(NUM_REQUESTERS - 1);
  localparam logic [BC_W-1:0] c_max_burst = BC_W'(MAX_BURST);

  arb_state_t                r_state;
  logic [ID_W-1:0]           r_rr_ptr;
  logic [ID_W-1:0]           r_grant_id;
  logic [NUM_REQUESTERS-1:0] r_grant_oh;
  logic                      r_grant_active;
  logic [BC_W-1:0]           r_burst_cnt;
  logic                      r_end_flag;
  logic [WIDTH-1:0]          r_tx_data;
  logic                      r_tx_start;

  logic [NUM_REQUESTERS-1:0] w_win_oh;
  logic [ID_W-1:0]           w_win_idx;
  logic                      w_win_any;
  logic                      w_cur_valid;
  logic                      w_cur_last;
  logic                      w_xfer;

  rr_pick #(
    .NUM_REQUESTERS (NUM_REQUESTERS)
  ) u_rr_pick (
    .i_req_valid (req_valid),
    .i_rr_ptr    (r_rr_ptr),
    .o_onehot    (w_win_oh),
    .o_idx       (w_win_idx),
    .o_any       (w_win_any)
  );

  assign w_cur_valid = |(req_valid & r_grant_oh);
  assign w_cur_last  = |(req_last & r_grant_oh);
  assign req_ready   = (r_state == ST_SEND && !tx_busy) ? r_grant_oh : '0;
  assign w_xfer      = |(req_valid & req_ready);

`ifdef UART_ARB_TAG_EN
  logic [WIDTH-1:0] w_tag_byte;
  assign w_tag_byte = WIDTH'(r_grant_id) | (WIDTH'(TAG_FLAG) << (WIDTH - 1));
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_rr_ptr       <= '0;
      r_grant_id     <= '0;
      r_grant_oh     <= '0;
      r_grant_active <= 1'b0;
      r_burst_cnt    <= '0;
      r_end_flag     <= 1'b0;
      r_tx_data      <= '0;
      r_tx_start     <= 1'b0;
    end else begin
      r_tx_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // The busy gate also covers a frame left running across a reset.
          if (!tx_busy && w_win_any) begin
            r_grant_id     <= w_win_idx;
            r_grant_oh     <= w_win_oh;
            r_grant_active <= 1'b1;
            r_burst_cnt    <= '0;
            r_end_flag     <= 1'b0;
            r_rr_ptr       <= (w_win_idx == c_last_id) ? '0 : w_win_idx + 1'b1;
`ifdef UART_ARB_TAG_EN
            r_state        <= ST_TAG;
`else
            r_state        <= ST_SEND;
`endif
          end
        end
`ifdef UART_ARB_TAG_EN
        ST_TAG: begin
          r_tx_data  <= w_tag_byte;
          r_tx_start <= 1'b1;
          r_end_flag <= 1'b0;
          r_state    <= ST_START;
        end
`endif
        ST_SEND: begin
          if (w_xfer) begin
            r_tx_data   <= req_data[r_grant_id];
            r_burst_cnt <= r_burst_cnt + 1'b1;
            r_end_flag  <= w_cur_last;
            r_tx_start  <= 1'b1;
            r_state     <= ST_START;
          end else if (!w_cur_valid) begin
            r_grant_active <= 1'b0;
            r_grant_oh     <= '0;
            r_state        <= ST_IDLE;
          end
        end
        ST_START: begin
          r_state <= ST_WAIT_HI;
        end
        ST_WAIT_HI: begin
          if (tx_busy) begin
            r_state <= ST_WAIT_LO;
          end
        end
        ST_WAIT_LO: begin
          if (!tx_busy) begin
            if (r_end_flag || r_burst_cnt == c_max_burst) begin
              r_grant_active <= 1'b0;
              r_grant_oh     <= '0;
              r_state        <= ST_IDLE;
            end else begin
              r_state <= ST_SEND;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx_data      = r_tx_data;
  assign tx_start     = r_tx_start;
  assign grant_id     = r_grant_id;
  assign grant_active = r_grant_active;

endmodule

`default_nettype wire
